fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Single-port framebuffer arbiter between VGA scan-out and the drawing side. Each `p_tick` from the sync generator gets a guaranteed read slot to fetch the current pixel colour, and `rgb` is driven to the colour DAC pins. All remaining cycles go to a valid/ready pixel-write port and an optional full-screen clear engine. It sits between `Vga_Sync`, the drawing engine and one synchronous-read block RAM holding a down-scaled 3-bit colour image.

## Interface
- `FB_W`, 160: framebuffer width in pixels.
- `FB_H`, 120: framebuffer height in pixels.
- `SCALE`, 2: log2 of screen-to-framebuffer scaling; screen coordinates are shifted right by `SCALE`.
- `ADDR_W`, 15: RAM address width; must satisfy 2^ADDR_W ≥ FB_W*FB_H.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `p_tick` in 1: pixel strobe from `Vga_Sync`, one `clk` wide.
- `video_on` in 1: visible-area flag from `Vga_Sync`.
- `pixel_x`, `pixel_y` in 10 each: current scan position.
- `wr_valid` in 1: draw write request.
- `wr_ready` out 1: draw write accepted this cycle.
- `wr_x`, `wr_y` in 10 each: framebuffer coordinates of the write.
- `wr_color` in 3: write colour.
- `clr_req` in 1: start full-screen clear (only with `FB_CLEAR_EN`).
- `clr_color` in 3: clear colour.
- `clr_busy` out 1: clear in progress.
- `ram_addr` out ADDR_W, `ram_we` out 1, `ram_wdata` out 3: RAM port.
- `ram_rdata` in 3: RAM read data, valid one `clk` after the address.
- `rgb` out 3: colour to the DAC pins.

## Operation
- **Slot rule.** A cycle with `p_tick=1` and `video_on=1` is a READ slot. All other cycles are WRITE slots.
- **READ slot.**
  - `ram_addr = (pixel_y>>SCALE)*FB_W + (pixel_x>>SCALE)`, truncated to ADDR_W.
  - `ram_we=0`, `wr_ready=0`, and the clear engine stalls.
- **WRITE slot priority:** CLEAR engine first, then the draw port.
- **Draw port.**
  - `wr_ready=1` in every WRITE slot while the FSM is IDLE.
  - A transfer completes on `wr_valid & wr_ready`.
  - If `wr_x<FB_W` and `wr_y<FB_H`: `ram_we=1`, `ram_addr = wr_y*FB_W + wr_x`, `ram_wdata = wr_color`.
  - Out-of-range coordinates are accepted and dropped: `ram_we=0`.
- **FSM states:** IDLE, CLEAR.
  - IDLE → CLEAR on `clr_req=1`. The clear counter loads 0 and `clr_color` is latched.
  - In CLEAR, each WRITE slot writes the latched colour at the counter address, then increments the counter.
  - After writing address FB_W*FB_H−1, CLEAR → IDLE.
  - `clr_req` is ignored while in CLEAR.
  - In CLEAR, `wr_ready=0` always.
- **Scan-out pipeline.**
  - A valid bit is registered with each READ slot.
  - One cycle later `ram_rdata` is captured into the colour register.
  - `rgb` = colour register while the delayed `video_on` is 1, else 3'b000.
- **Idle outputs.** When neither a read nor a write is issued, `ram_we=0` and `ram_addr` holds its previous value.

## Timing
- Reset values (applied on the first rising `clk` with `reset=0`):
  - `rgb=0`, `wr_ready=0`, `clr_busy=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
  - FSM in IDLE, clear counter 0, pipeline valid bits 0.
- `ram_addr`, `ram_we` and `ram_wdata` are combinational from the current slot decision. `wr_ready` is combinational from `p_tick`, `video_on` and the FSM state.
- Scan-out latency: the pixel addressed at a READ-slot edge appears on `rgb` 2 `clk` later and holds until the next update.
- `clr_busy` is registered: it rises the cycle after `clr_req` is sampled and falls the cycle after the last clear write.
- With `p_tick` every 4th `clk`, a clear takes at most FB_W*FB_H*4/3 + 1 cycles during active video, and exactly FB_W*FB_H cycles during blanking.
- Reset asserted mid-clear aborts it: FSM returns to IDLE and the partially cleared RAM is left as is.
- Reset asserted mid-transfer: no RAM write is issued in the reset cycle.
- A `wr_valid` arriving in the same cycle as a READ slot waits (`wr_ready=0`). The requester must hold `wr_x`, `wr_y` and `wr_color` stable until accepted.

## Configuration
- Macro: `FB_CLEAR_EN`.
- Defined: the CLEAR state, clear counter, `clr_color` latch and `clr_busy` logic are compiled in, as described above.
- Undefined:
  - The FSM is permanently IDLE and `clr_req` and `clr_color` are ignored.
  - `clr_busy` is tied to 0.
  - `wr_ready` depends only on the slot rule.

## Test plan
- **Single write:** `wr_valid=1`, `wr_x=5`, `wr_y=3`, `wr_color=3'b101` in blanking → same cycle `wr_ready=1`, `ram_we=1`, `ram_addr=485`, `ram_wdata=3'b101`.
- **Collision:** `wr_valid` held while a READ slot occurs at `pixel_x=40`, `pixel_y=8` → `ram_addr=330`, `ram_we=0`, `wr_ready=0`; the write completes in the next cycle.
- **Out-of-range:** `wr_x=160`, `wr_y=0`, `wr_valid=1` → `wr_ready=1`, `ram_we=0`, RAM unchanged.
- **Scan-out:** RAM model returns 3'b110 → `rgb=3'b110` exactly 2 `clk` after the READ-slot edge; with `video_on=0` → `rgb=3'b000`.
- **Clear, full run (`FB_CLEAR_EN`):** `clr_req` pulse with `clr_color=3'b010` in blanking → 19200 writes to addresses 0..19199 in order, then `clr_busy` falls and `wr_ready` returns to 1.
- **Clear, reset mid-run:** `reset=0` at write 1000 → next cycle FSM IDLE, `clr_busy=0`, `ram_we=0`, `rgb=0`.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter between VGA scan-out and the drawing side.
// Latency: RAM port outputs are combinational from the slot decision; rgb shows a READ-slot pixel 2 clk later.
// Backpressure: wr_ready drops during READ slots and while a clear is running; requester holds data until accepted.
//
// Ports: clk/reset (sync, active-low); p_tick/video_on/pixel_x/pixel_y from the sync generator;
//   wr_valid/wr_ready/wr_x/wr_y/wr_color draw write port; clr_req/clr_color/clr_busy clear engine;
//   ram_addr/ram_we/ram_wdata/ram_rdata synchronous-read RAM port; rgb to the colour DAC.
// Optional feature: define FB_CLEAR_EN to compile in the full-screen clear engine.
module fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int SCALE  = 2,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [2:0]        wr_color,
  input  logic              clr_req,
  input  logic [2:0]        clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [2:0]        ram_wdata,
  input  logic [2:0]        ram_rdata,
  output logic [2:0]        rgb
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  logic              read_slot;
  logic              in_clear;
  logic [ADDR_W-1:0] clr_cnt;
  logic [2:0]        clr_color_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_range;
  logic [ADDR_W-1:0] addr_q;
  logic              issue;

  assign read_slot = p_tick & video_on;

  // Screen position scaled down to framebuffer coordinates, truncated to the RAM width.
  assign rd_addr = ADDR_W'(pixel_y >> SCALE) * ADDR_W'(FB_W) + ADDR_W'(pixel_x >> SCALE);
  assign wr_addr = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);
  assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);

`ifdef FB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      clr_color_q <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      if (state == IDLE && clr_req)
        clr_color_q <= clr_color;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        // The counter only advances in cycles where the clear actually wrote.
        if (!read_slot) begin
          if (clr_cnt == LAST_ADDR) begin
            state_nxt   = IDLE;
            clr_cnt_nxt = '0;
          end else begin
            clr_cnt_nxt = clr_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_clear = (state == CLEAR);
  // state is a register, so this is a registered busy flag.
  assign clr_busy = in_clear;
`else
  logic unused_clr;

  assign in_clear    = 1'b0;
  assign clr_cnt     = '0;
  assign clr_color_q = '0;
  assign clr_busy    = 1'b0;
  assign unused_clr  = ^{clr_req, clr_color, LAST_ADDR};
`endif

  // Slot decision: READ slot wins, then clear, then draw. Nothing is issued while reset is held.
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = 3'b000;
    wr_ready  = 1'b0;
    issue     = 1'b0;
    if (!reset) begin
      ram_addr = '0;
    end else if (read_slot) begin
      ram_addr = rd_addr;
      issue    = 1'b1;
    end else if (in_clear) begin
      ram_we    = 1'b1;
      ram_addr  = clr_cnt;
      ram_wdata = clr_color_q;
      issue     = 1'b1;
    end else begin
      wr_ready = 1'b1;
      // Out-of-range writes are accepted but dropped, leaving the address bus parked.
      if (wr_valid && wr_in_range) begin
        ram_we    = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = wr_color;
        issue     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      addr_q <= '0;
    else if (issue)
      addr_q <= ram_addr;
  end

  // Scan-out: rd_vld marks the cycle RAM data returns; video_on is delayed twice to line up with color_q.
  logic       rd_vld_q;
  logic       von_q1;
  logic       von_q2;
  logic [2:0] color_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_vld_q <= 1'b0;
      von_q1   <= 1'b0;
      von_q2   <= 1'b0;
      color_q  <= 3'b000;
    end else begin
      rd_vld_q <= read_slot;
      von_q1   <= video_on;
      von_q2   <= von_q1;
      if (rd_vld_q)
        color_q <= ram_rdata;
    end
  end

  assign rgb = von_q2 ? color_q : 3'b000;

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick, video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x, wr_y;
  logic [2:0]  wr_color;
  logic        clr_req;
  logic [2:0]  clr_color;
  logic        clr_busy;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;
  logic [2:0]  rgb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [2:0]  data;
  } wexp_t;

  wexp_t      wq[$];
  logic [2:0] rq[$];

  logic [2:0] mem [0:32767];
  logic       mem_wipe;

  fb_arbiter dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rgb(rgb)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model, read-before-write.
  always @(posedge clk) begin
    if (mem_wipe) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 3'b000;
      ram_rdata <= 3'b000;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One write-port cycle in blanking; expectation pushed at drive time, popped at the sample point.
  task automatic do_write(input int x, input int y, input logic [2:0] c);
    wexp_t e;
    wr_valid = 1'b1;
    wr_x = 10'(x);
    wr_y = 10'(y);
    wr_color = c;
    e.we = (x < 160) && (y < 120);
    e.addr = 15'(y * 160 + x);
    e.data = c;
    wq.push_back(e);
    @(negedge clk);
    e = wq.pop_front();
    chk("wr_ready", 32'(wr_ready), 32'd1);
    chk("wr_we", 32'(ram_we), 32'(e.we));
    if (e.we) begin
      chk("wr_addr", 32'(ram_addr), 32'(e.addr));
      chk("wr_data", 32'(ram_wdata), 32'(e.data));
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  initial begin
    logic [14:0] held_addr;
    int n;
    int bad;
    int cyc;

    reset = 1'b0; mem_wipe = 1'b1;
    p_tick = 0; video_on = 0; pixel_x = 0; pixel_y = 0;
    wr_valid = 1'b1; wr_x = 10'd5; wr_y = 10'd3; wr_color = 3'b111;
    clr_req = 0; clr_color = 0;

    // Reset held with a pending in-range write: nothing may reach the RAM.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    @(posedge clk); #1;
    reset = 1'b1; mem_wipe = 1'b0; wr_valid = 1'b0;

    // Single write in blanking.
    @(posedge clk); #1;
    do_write(5, 3, 3'b101);
    chk("mem485", 32'(mem[485]), 5);

    // Collision: READ slot beats the waiting write, which completes the next cycle.
    wr_valid = 1; wr_x = 10'd7; wr_y = 10'd2; wr_color = 3'b011;
    p_tick = 1; video_on = 1; pixel_x = 10'd40; pixel_y = 10'd8;
    @(negedge clk);
    chk("col_addr", 32'(ram_addr), 330);
    chk("col_we", 32'(ram_we), 0);
    chk("col_ready", 32'(wr_ready), 0);
    @(posedge clk); #1;
    p_tick = 0;
    @(negedge clk);
    chk("col2_ready", 32'(wr_ready), 1);
    chk("col2_we", 32'(ram_we), 1);
    chk("col2_addr", 32'(ram_addr), 327);
    @(posedge clk); #1;
    wr_valid = 0; video_on = 0;

    // Out-of-range write is accepted and dropped; the address bus stays parked.
    held_addr = 15'd327;
    do_write(160, 0, 3'b111);
    chk("oor_mem160", 32'(mem[160]), 0);
    wr_valid = 1; wr_x = 10'd0; wr_y = 10'd200;
    @(negedge clk);
    chk("oor_y_we", 32'(ram_we), 0);
    chk("oor_hold_addr", 32'(ram_addr), 32'(held_addr));
    @(posedge clk); #1;
    wr_valid = 0;

    // Scan-out: write a row of pixels, then read them back on a p_tick every 4th clk.
    for (int i = 0; i < 4; i++) do_write(i, 1, 3'(i + 3));
    for (int i = 0; i < 4; i++) begin
      p_tick = 1; video_on = 1; pixel_x = 10'(i * 4 + 1); pixel_y = 10'd5;
      rq.push_back(3'(i + 3));
      @(negedge clk);
      chk("scan_addr", 32'(ram_addr), 32'(160 + i));
      @(posedge clk); #1;
      p_tick = 0;
      @(posedge clk);
      @(negedge clk);
      chk("scan_rgb", 32'(rgb), 32'(rq.pop_front()));
      @(negedge clk);
      chk("scan_hold", 32'(rgb), 32'(i + 3));
      @(posedge clk); #1;
    end
    video_on = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("blank_rgb", 32'(rgb), 0);
    @(posedge clk); #1;

`ifdef FB_CLEAR_EN
    // Full clear in blanking.
    clr_req = 1; clr_color = 3'b010;
    @(posedge clk); #1;
    clr_req = 0; clr_color = 3'b111;
    n = 0; bad = 0; cyc = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (!clr_busy) break;
      cyc++;
      if (wr_ready) bad++;
      if (ram_we) begin
        if (ram_addr !== 15'(n) || ram_wdata !== 3'b010) bad++;
        n++;
      end
    end
    chk("clr_writes", 32'(n), 19200);
    chk("clr_cycles", 32'(cyc), 19200);
    chk("clr_order_errs", 32'(bad), 0);
    chk("clr_busy_end", 32'(clr_busy), 0);
    chk("clr_ready_end", 32'(wr_ready), 1);
    chk("clr_mem_last", 32'(mem[19199]), 2);
    chk("clr_mem_past", 32'(mem[19200]), 0);
    @(posedge clk); #1;

    // Second clear aborted by reset after write 1000.
    clr_req = 1; clr_color = 3'b101;
    @(posedge clk); #1;
    clr_req = 0;
    n = 0;
    for (int k = 0; k < 5000 && n <= 1000; k++) begin
      @(negedge clk);
      if (ram_we) n++;
    end
    chk("abort_reached", 32'(n), 1001);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("abort_we_in_rst", 32'(ram_we), 0);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("abort_busy", 32'(clr_busy), 0);
    chk("abort_we", 32'(ram_we), 0);
    chk("abort_rgb", 32'(rgb), 0);
    chk("abort_ready", 32'(wr_ready), 1);
    chk("abort_mem1000", 32'(mem[1000]), 5);
    chk("abort_mem1001", 32'(mem[1001]), 2);
    @(posedge clk); #1;
`else
    // Without the clear engine, clr_req changes nothing.
    clr_req = 1; clr_color = 3'b010;
    @(posedge clk); #1;
    clr_req = 0;
    @(negedge clk);
    chk("noclr_busy", 32'(clr_busy), 0);
    chk("noclr_ready", 32'(wr_ready), 1);
    chk("noclr_we", 32'(ram_we), 0);
    @(posedge clk); #1;
    do_write(159, 119, 3'b001);
    chk("noclr_mem0", 32'(mem[0]), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
